aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
- Iterative AES encryption core: initial AddRoundKey, then NROUNDS rounds of SubBytes → ShiftRows → MixColumns → AddRoundKey, one datapath stage per cycle.
- Final round skips MixColumns.
- Start and result handshakes; round keys come from an external key store indexed by round_o.
- Reuses the existing subBytes, ShiftRows and Mix_columns blocks; successor to the fixed single-round FSM.

Parameters:
- WIDTH, 8, bits per state byte.
- DIM, 4, state matrix dimension (DIM×DIM bytes).
- NROUNDS, 10, number of rounds (≥1; 10/12/14 for AES-128/192/256).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- start_i  in  1  request; accepted only in IDLE.
- data_i  in  DIM*DIM*WIDTH  plaintext, sampled on accept.
- rkey_i  in  DIM*DIM*WIDTH  round key for round_o, combinationally valid in the same cycle.
- round_o  out  $clog2(NROUNDS+1)  current round-key index.
- busy_o  out  1  high from the cycle after accept until DONE exits.
- done_o  out  1  result valid.
- ack_i  in  1  consumer accepts result.
- data_o  out  DIM*DIM*WIDTH  ciphertext; zero whenever done_o=0.

Interface decision: one clock clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Packing: byte k = bits [WIDTH*k+WIDTH-1 : WIDTH*k]; mat[i][j] = byte i*DIM+j. This matches the existing subBytes/ShiftRows/Mix_columns convention.
- States:
  - IDLE: round_o=0. On start_i, st <= data_i ^ rkey_i; rnd <= 1; go to SUB.
  - SUB: st <= ShiftRows(SubBytes(st)); go to MIX.
  - MIX: st <= (rnd==NROUNDS) ? st : MixColumns(st); go to ADD.
  - ADD: st <= st ^ rkey_i with round_o=rnd. If rnd==NROUNDS go to DONE; else rnd++ and go to SUB.
  - DONE: done_o=1, data_o=st. On ack_i go to IDLE; otherwise hold.
- round_o equals rnd in SUB, MIX and ADD; 0 in IDLE and DONE.
- Latency: accept at cycle t gives done_o=1 at t+3*NROUNDS+1. done_o holds until ack_i.
- Throughput: one block per 3*NROUNDS+2 cycles minimum (includes the IDLE cycle).
- Reset (any state, including mid-round):
  - state=IDLE, st=0, rnd=0.
  - done_o=0, busy_o=0, round_o=0, data_o=0.
- start_i outside IDLE is ignored; it is not queued.
- ack_i outside DONE is ignored.
- ack_i and start_i together in DONE: go to IDLE; start_i is not accepted that cycle.
- start_i held high continuously: a new accept every 3*NROUNDS+2 cycles once ack_i is given.
- rkey_i is sampled only in IDLE-accept and ADD cycles; its value elsewhere is don't-care.
- NROUNDS=1: sequence IDLE→SUB→MIX(bypass)→ADD→DONE.
- All XOR is bitwise, full width, no carries.
- Illegal state encoding: next = IDLE; registers cleared.

Decomposition:
- Package aes_pkg:
  - matrix_t typedef (parametrised via WIDTH/DIM).
  - state enum {IDLE, SUB, MIX, ADD, DONE}.
  - vec2mat / mat2vec functions.
  - AES_BLK_BITS = DIM*DIM*WIDTH constant.
- One new sub-module, aes_add_round_key: purely combinational state ^ key, instanced for both whitening and ADD via a mux on the operand.
- subBytes, ShiftRows and Mix_columns are instanced unchanged.

Test Plan:
1. FIPS-197 App. B.
   - Stimulus: data_i=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c expanded by a bench key-store model driving rkey_i from round_o.
   - Response: done_o rises exactly 31 cycles after accept; data_o=3925841d02dc09fbdc118597196a0b32.
2. Handshake hold.
   - Stimulus: withhold ack_i for 20 cycles after done.
   - Response: data_o and done_o stable; busy_o=1. ack_i pulse → IDLE next cycle with data_o=0, done_o=0.
3. Reset mid-operation.
   - Stimulus: assert rst_i while round_o=5 (MIX state).
   - Response: next cycle all outputs 0, IDLE. A fresh vector-1 run still gives the correct ciphertext.
4. Ignored requests.
   - Stimulus: pulse start_i with different data during SUB/ADD; raise ack_i before done.
   - Response: no effect on result or timing.
5. Back-to-back.
   - Stimulus: start_i held high, ack_i asserted on the first done cycle.
   - Response: second accept 32 cycles after the first; both results correct. Check the start+ack collision cycle.
6. NROUNDS=1, all-zero key.
   - Stimulus: data_i = bytes 00..0F.
   - Response: data_o = ShiftRows(SubBytes(data_i)), no MixColumns; done_o at t+4; round_o sequence 0,1,1,1,0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the iterative round engine.
// Bus byte k maps to mat[k/4][k%4]; mat[i] is AES column 3-i and mat[i][j] is row 3-j, so FIPS hex strings map onto the bus directly.
package aes_pkg;
    localparam int AES_WIDTH    = 8;
    localparam int AES_DIM      = 4;
    localparam int AES_BLK_BITS = AES_DIM * AES_DIM * AES_WIDTH;

    typedef logic [AES_DIM-1:0][AES_DIM-1:0][AES_WIDTH-1:0] matrix_t;

    typedef enum logic [2:0] {IDLE, SUB, MIX, ADD, DONE} aes_state_e;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic matrix_t vec2mat(input logic [AES_BLK_BITS-1:0] v);
        return matrix_t'(v);
    endfunction

    function automatic logic [AES_BLK_BITS-1:0] mat2vec(input matrix_t m);
        return m;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] idx;
        idx = ~b;
        return SBOX[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/Mix_columns.sv
// AES MixColumns: each column multiplied by the fixed {02,03,01,01} circulant in GF(2^8).
module Mix_columns
    import aes_pkg::*;
(
    input  logic [AES_BLK_BITS-1:0] data_i,
    output logic [AES_BLK_BITS-1:0] data_o
);
    matrix_t m_in;
    matrix_t m_out;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        m_in  = vec2mat(data_i);
        m_out = m_in;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = m_in[3-c][3];
            a1 = m_in[3-c][2];
            a2 = m_in[3-c][1];
            a3 = m_in[3-c][0];
            m_out[3-c][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            m_out[3-c][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            m_out[3-c][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            m_out[3-c][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        data_o = mat2vec(m_out);
    end
endmodule

// File: rtl/ShiftRows.sv
// AES ShiftRows: row r rotates left by r columns.
module ShiftRows
    import aes_pkg::*;
(
    input  logic [AES_BLK_BITS-1:0] data_i,
    output logic [AES_BLK_BITS-1:0] data_o
);
    matrix_t m_in;
    matrix_t m_out;

    always_comb begin
        m_in  = vec2mat(data_i);
        m_out = m_in;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m_out[3-c][3-r] = m_in[3-((c+r)%4)][3-r];
            end
        end
        data_o = mat2vec(m_out);
    end
endmodule

// File: rtl/aes_add_round_key.sv
// AddRoundKey: full-width bitwise XOR of state and round key.
module aes_add_round_key
    import aes_pkg::*;
(
    input  logic [AES_BLK_BITS-1:0] state_i,
    input  logic [AES_BLK_BITS-1:0] key_i,
    output logic [AES_BLK_BITS-1:0] data_o
);
    assign data_o = state_i ^ key_i;
endmodule

// File: rtl/subBytes.sv
// Byte-wise AES S-box substitution over the whole state.
module subBytes
    import aes_pkg::*;
(
    input  logic [AES_BLK_BITS-1:0] data_i,
    output logic [AES_BLK_BITS-1:0] data_o
);
    always_comb begin
        data_o = '0;
        for (int k = 0; k < AES_BLK_BITS / 8; k++) begin
            data_o[8*k +: 8] = sbox(data_i[8*k +: 8]);
        end
    end
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption: whitening on accept, then SUB/MIX/ADD per round, one stage per cycle.
// state | meaning
// IDLE  | wait for start_i; whiten data_i with round key 0
// SUB   | SubBytes + ShiftRows
// MIX   | MixColumns, bypassed in the final round
// ADD   | AddRoundKey with key for round_o; advance or finish
// DONE  | hold result until ack_i
module aes_round_engine
    import aes_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DIM     = 4,
    parameter  int NROUNDS = 10,
    localparam int BLK     = DIM * DIM * WIDTH,
    localparam int RW      = $clog2(NROUNDS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [BLK-1:0] data_i,
    input  logic [BLK-1:0] rkey_i,
    output logic [RW-1:0]  round_o,
    output logic          busy_o,
    output logic          done_o,
    input  logic          ack_i,
    output logic [BLK-1:0] data_o
);
    aes_state_e     state_q, state_d;
    logic [BLK-1:0] st_q, st_d;
    logic [RW-1:0]  rnd_q, rnd_d;
    logic [BLK-1:0] ark_in, ark_out, sb_out, sr_out, mc_out;
    logic           last_round;

    assign last_round = (rnd_q == RW'(NROUNDS));
    // One XOR instance serves both the initial whitening and every ADD stage.
    assign ark_in     = (state_q == IDLE) ? data_i : st_q;

    aes_add_round_key u_ark (.state_i(ark_in), .key_i(rkey_i), .data_o(ark_out));
    subBytes          u_sb  (.data_i(st_q),   .data_o(sb_out));
    ShiftRows         u_sr  (.data_i(sb_out), .data_o(sr_out));
    Mix_columns       u_mc  (.data_i(st_q),   .data_o(mc_out));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        round_o = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        data_o  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    st_d    = ark_out;
                    rnd_d   = RW'(1);
                    state_d = SUB;
                end
            end
            SUB: begin
                round_o = rnd_q;
                busy_o  = 1'b1;
                st_d    = sr_out;
                state_d = MIX;
            end
            MIX: begin
                round_o = rnd_q;
                busy_o  = 1'b1;
                if (!last_round) st_d = mc_out;
                state_d = ADD;
            end
            ADD: begin
                round_o = rnd_q;
                busy_o  = 1'b1;
                st_d    = ark_out;
                if (last_round) begin
                    state_d = DONE;
                end else begin
                    rnd_d   = rnd_q + RW'(1);
                    state_d = SUB;
                end
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                data_o = st_q;
                if (ack_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                st_d    = '0;
                rnd_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 App. B vector, handshake, reset, collisions, NROUNDS=1.
module tb_aes_round_engine;
    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] JUNK = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] PT1  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT1  = 128'h76676b632b6f7cfec577d7307bab01f2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i, ack_i, busy_o, done_o;
    logic [127:0] data_i, rkey, data_o;
    logic [3:0]   round_o;
    logic         start1, ack1, busy1, done1;
    logic [127:0] data1, data_o1;
    logic [127:0] zero_key = '0;
    logic [0:0]   round1;
    logic [127:0] rk [0:15];
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk_i = ~clk_i;

    // Key store: FIPS-197 expansion of 2b7e151628aed2a6abf7158809cf4f3c, addressed by round_o.
    assign rkey = (round_o <= 4'd10) ? rk[round_o] : '0;

    aes_round_engine #(.NROUNDS(10)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .data_i(data_i), .rkey_i(rkey),
        .round_o(round_o), .busy_o(busy_o), .done_o(done_o), .ack_i(ack_i), .data_o(data_o)
    );

    aes_round_engine #(.NROUNDS(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start1), .data_i(data1), .rkey_i(zero_key),
        .round_o(round1), .busy_o(busy1), .done_o(done1), .ack_i(ack1), .data_o(data_o1)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept PT, optionally pepper the run with ignored start/ack pulses, stop on done_o.
    task automatic run_block(input string tag, input bit disturb);
        int lat;
        lat = 40;
        for (int k = 1; k <= 40; k++) begin
            start_i = (k == 1) || (disturb && (k == 2 || k == 4));
            data_i  = (k == 1) ? PT : JUNK;
            ack_i   = disturb && (k == 10);
            tick();
            if (done_o) begin
                lat = k;
                break;
            end
            chk({tag, "_round"}, 128'(round_o), 128'((k - 1) / 3 + 1));
            chk({tag, "_out_zero"}, data_o, '0);
        end
        start_i = 1'b0;
        ack_i   = 1'b0;
        chk({tag, "_latency"}, 128'(lat), 128'd31);
        chk({tag, "_data"}, data_o, CT);
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    initial begin
        int k1, k2;
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 11; i < 16; i++) rk[i] = '0;
        start_i = 1'b0; ack_i = 1'b0; data_i = '0;
        start1  = 1'b0; ack1  = 1'b0; data1  = '0;

        rst_i = 1'b1;
        tick();
        tick();
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_round", 128'(round_o), 128'd0);
        chk("rst_data", data_o, '0);
        chk("rst1_done", 128'(done1), 128'd0);
        chk("rst1_data", data_o1, '0);
        rst_i = 1'b0;

        run_block("fips", 1'b0);

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_done", 128'(done_o), 128'd1);
            chk("hold_data", data_o, CT);
            chk("hold_busy", 128'(busy_o), 128'd1);
        end
        pulse_ack();
        chk("ack_done", 128'(done_o), 128'd0);
        chk("ack_data", data_o, '0);
        chk("ack_busy", 128'(busy_o), 128'd0);
        chk("ack_round", 128'(round_o), 128'd0);

        start_i = 1'b1;
        data_i  = PT;
        tick();
        start_i = 1'b0;
        repeat (13) tick();
        chk("mid_round5", 128'(round_o), 128'd5);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_done", 128'(done_o), 128'd0);
        chk("midrst_busy", 128'(busy_o), 128'd0);
        chk("midrst_round", 128'(round_o), 128'd0);
        chk("midrst_data", data_o, '0);
        run_block("after_rst", 1'b0);
        pulse_ack();

        run_block("ignored", 1'b1);
        pulse_ack();

        start_i = 1'b1;
        data_i  = PT;
        k1 = 40;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o) begin
                k1 = k;
                break;
            end
        end
        chk("b2b_first_lat", 128'(k1), 128'd31);
        chk("b2b_first_data", data_o, CT);
        pulse_ack();
        chk("b2b_collide_done", 128'(done_o), 128'd0);
        chk("b2b_collide_busy", 128'(busy_o), 128'd0);
        chk("b2b_collide_round", 128'(round_o), 128'd0);
        tick();
        chk("b2b_accept_busy", 128'(busy_o), 128'd1);
        chk("b2b_accept_round", 128'(round_o), 128'd1);
        k2 = 40;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o) begin
                k2 = k;
                break;
            end
        end
        chk("b2b_second_lat", 128'(k2), 128'd30);
        chk("b2b_second_data", data_o, CT);
        start_i = 1'b0;
        pulse_ack();

        chk("n1_idle_round", 128'(round1), 128'd0);
        start1 = 1'b1;
        data1  = PT1;
        tick();
        start1 = 1'b0;
        chk("n1_sub_round", 128'(round1), 128'd1);
        tick();
        chk("n1_mix_round", 128'(round1), 128'd1);
        tick();
        chk("n1_add_round", 128'(round1), 128'd1);
        chk("n1_add_done", 128'(done1), 128'd0);
        tick();
        chk("n1_done_round", 128'(round1), 128'd0);
        chk("n1_done", 128'(done1), 128'd1);
        chk("n1_data", data_o1, CT1);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("n1_ack_done", 128'(done1), 128'd0);
        chk("n1_ack_data", data_o1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
